hazard_sb: RTL and testbench

Scoreboarded hazard unit for the 5-stage MIPS pipeline: forwarding selection, load-use and branch-operand stalls, flush generation, and an NCH-channel scoreboard that lets multiply/divide units run non-blocking (E is no longer frozen during a divide). Each channel holds one in-flight long-latency result identified by a destination tag; younger instructions stall in D only when they read or overwrite a pending tag, or need a busy unit. It sits beside the datapath, and the per-stage pipeline registers consume its stall/flush outputs.

---
 rtl/hazard_sb.sv | 163 ++++++++++++++++
 tb/tb_hazard_sb.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_sb.sv
// hazard_sb -- hazard unit for the 5-stage MIPS pipeline with a
// per-channel scoreboard for long-latency multiply/divide results.
//
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   rsD, rtD                     D-stage GPR sources (5 bits)
//   srcAD, srcBD, dstD           D-stage source/destination tags (0 = unused)
//   mcD                          D instruction needs long-latency channel k
//   branchD                      D instruction compares registers (branch/jr)
//   rsE, rtE, writeregE          E-stage register numbers
//   regwriteE, memtoregE         E-stage control
//   issueE, tagE                 channel-k op leaves E with destination tag
//   doneX                        channel k writes its result this cycle
//   writeregM, regwriteM         M-stage destination
//   memtoregM                    M-stage instruction is a load
//   writeregW, regwriteW         W-stage destination
//   judgeM, excM                 mispredict / exception resolved in M
//   forwardAE, forwardBE         E operand select: 10 = M, 01 = W, 00 = RF
//   forwardAD, forwardBD         D comparator forward from M
//   stallF, stallD, stallE       stage stalls
//   flushD, flushE, flushM, flushW  stage flushes
//   killE                        discard the channel-k issue this cycle
//   busy                         channel-k scoreboard state
//   stallcnt                     saturating count of stallD cycles
module hazard_sb #(
    parameter int NCH = 2,
    parameter int TW  = 6,
    parameter int CW  = 16
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [4:0]      rsD,
    input  logic [4:0]      rtD,
    input  logic [TW-1:0]   srcAD,
    input  logic [TW-1:0]   srcBD,
    input  logic [TW-1:0]   dstD,
    input  logic [NCH-1:0]  mcD,
    input  logic            branchD,
    input  logic [4:0]      rsE,
    input  logic [4:0]      rtE,
    input  logic [4:0]      writeregE,
    input  logic            regwriteE,
    input  logic            memtoregE,
    input  logic [NCH-1:0]  issueE,
    input  logic [TW-1:0]   tagE,
    input  logic [NCH-1:0]  doneX,
    input  logic [4:0]      writeregM,
    input  logic            regwriteM,
    input  logic            memtoregM,
    input  logic [4:0]      writeregW,
    input  logic            regwriteW,
    input  logic            judgeM,
    input  logic            excM,
    output logic [1:0]      forwardAE,
    output logic [1:0]      forwardBE,
    output logic            forwardAD,
    output logic            forwardBD,
    output logic            stallF,
    output logic            stallD,
    output logic            stallE,
    output logic            flushD,
    output logic            flushE,
    output logic            flushM,
    output logic            flushW,
    output logic [NCH-1:0]  killE,
    output logic [NCH-1:0]  busy,
    output logic [CW-1:0]   stallcnt
);

    logic [NCH-1:0] busy_q;
    logic [TW-1:0]  tag_q [NCH];
    logic [CW-1:0]  cnt_q;
    logic [NCH-1:0] vi;
    logic           redirect;
    logic           lwstall, brstall, sbstall, hstall;

    // ---------------- forwarding ----------------
    always_comb begin
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        if (rsE != 5'd0 && regwriteM && rsE == writeregM)
            forwardAE = 2'b10;
        else if (rsE != 5'd0 && regwriteW && rsE == writeregW)
            forwardAE = 2'b01;
        if (rtE != 5'd0 && regwriteM && rtE == writeregM)
            forwardBE = 2'b10;
        else if (rtE != 5'd0 && regwriteW && rtE == writeregW)
            forwardBE = 2'b01;
    end

    assign forwardAD = (rsD != 5'd0) && regwriteM && (rsD == writeregM);
    assign forwardBD = (rtD != 5'd0) && regwriteM && (rtD == writeregM);

    // ---------------- stall detection ----------------
    assign lwstall = memtoregE && (writeregE != 5'd0) &&
                     ((rsD == writeregE) || (rtD == writeregE));

    assign brstall = branchD &&
                     ((regwriteE && (writeregE != 5'd0) &&
                       ((writeregE == rsD) || (writeregE == rtD))) ||
                      (memtoregM && ((writeregM == rsD) || (writeregM == rtD))));

    // RAW/WAW against any pending tag, plus structural conflict on a busy unit.
    always_comb begin
        sbstall = 1'b0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (busy_q[k]) begin
                if (tag_q[k] != '0 &&
                    ((srcAD != '0 && srcAD == tag_q[k]) ||
                     (srcBD != '0 && srcBD == tag_q[k]) ||
                     (dstD  != '0 && dstD  == tag_q[k])))
                    sbstall = 1'b1;
                if (mcD[k])
                    sbstall = 1'b1;
            end
        end
    end

    assign hstall   = lwstall | brstall | sbstall;
    assign redirect = judgeM | excM;

    assign stallD = hstall;
    assign stallF = hstall & ~excM;
    assign stallE = 1'b0;
    assign flushD = redirect;
    assign flushE = hstall | redirect;
    assign flushM = excM;
    assign flushW = excM;

    // ---------------- scoreboard ----------------
    assign vi    = issueE & ~{NCH{redirect}};
    assign killE = issueE &  {NCH{redirect}};

    // A busy channel belongs to an older, committed op, so redirects never
    // clear it; only completion or reset does.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_q <= '0;
            for (int unsigned k = 0; k < NCH; k++)
                tag_q[k] <= '0;
        end else begin
            for (int unsigned k = 0; k < NCH; k++) begin
                if (vi[k]) begin
                    busy_q[k] <= 1'b1;
                    tag_q[k]  <= tagE;
                end else if (doneX[k] && busy_q[k]) begin
                    busy_q[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            cnt_q <= '0;
        else if (hstall && cnt_q != '1)
            cnt_q <= cnt_q + CW'(1);
    end

    assign busy     = busy_q;
    assign stallcnt = cnt_q;

endmodule

// File: tb/tb_hazard_sb.sv
module tb_hazard_sb;

    logic        clk = 1'b0;
    logic        resetn;
    logic [4:0]  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic [5:0]  srcAD, srcBD, dstD, tagE;
    logic [1:0]  mcD, issueE, doneX;
    logic        branchD, regwriteE, memtoregE, regwriteM, memtoregM, regwriteW;
    logic        judgeM, excM;
    logic [1:0]  forwardAE, forwardBE, killE, busy;
    logic        forwardAD, forwardBD;
    logic        stallF, stallD, stallE, flushD, flushE, flushM, flushW;
    logic [15:0] stallcnt;

    int errors = 0;
    int checks = 0;

    hazard_sb #(.NCH(2), .TW(6), .CW(16)) dut (
        .clk(clk), .resetn(resetn),
        .rsD(rsD), .rtD(rtD), .srcAD(srcAD), .srcBD(srcBD), .dstD(dstD),
        .mcD(mcD), .branchD(branchD),
        .rsE(rsE), .rtE(rtE), .writeregE(writeregE),
        .regwriteE(regwriteE), .memtoregE(memtoregE),
        .issueE(issueE), .tagE(tagE), .doneX(doneX),
        .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
        .writeregW(writeregW), .regwriteW(regwriteW),
        .judgeM(judgeM), .excM(excM),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .forwardAD(forwardAD), .forwardBD(forwardBD),
        .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
        .killE(killE), .busy(busy), .stallcnt(stallcnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit m_busy [2];
    int m_tag  [2];
    int m_cnt;

    function automatic int fwd_e(input int src);
        if (src != 0 && regwriteM && src == int'(writeregM)) return 2;
        if (src != 0 && regwriteW && src == int'(writeregW)) return 1;
        return 0;
    endfunction

    function automatic bit pending_hit(input int t);
        for (int k = 0; k < 2; k++)
            if (m_busy[k] && t != 0 && m_tag[k] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit model_stall();
        int srcs [2];
        bit s;
        srcs[0] = int'(rsD);
        srcs[1] = int'(rtD);
        s = 1'b0;
        foreach (srcs[i]) begin
            if (memtoregE && writeregE != 0 && srcs[i] == int'(writeregE)) s = 1'b1;
            if (branchD && regwriteE && writeregE != 0 && srcs[i] == int'(writeregE)) s = 1'b1;
            if (branchD && memtoregM && srcs[i] == int'(writeregM)) s = 1'b1;
        end
        if (pending_hit(int'(srcAD)) || pending_hit(int'(srcBD)) || pending_hit(int'(dstD)))
            s = 1'b1;
        for (int k = 0; k < 2; k++)
            if (mcD[k] && m_busy[k]) s = 1'b1;
        return s;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_busy[0] = 0; m_busy[1] = 0;
            m_tag[0]  = 0; m_tag[1]  = 0;
            m_cnt     = 0;
        end else begin
            if (model_stall() && m_cnt < 65535) m_cnt++;
            for (int k = 0; k < 2; k++) begin
                if (issueE[k] && !judgeM && !excM) begin
                    m_busy[k] = 1;
                    m_tag[k]  = int'(tagE);
                end else if (doneX[k]) begin
                    m_busy[k] = 0;
                end
            end
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        bit st, rd;
        int kexp;
        st = model_stall();
        rd = judgeM || excM;
        kexp = rd ? int'(issueE) : 0;
        cmp("forwardAE", int'(forwardAE), fwd_e(int'(rsE)));
        cmp("forwardBE", int'(forwardBE), fwd_e(int'(rtE)));
        cmp("forwardAD", int'(forwardAD), int'(fwd_e(int'(rsD)) == 2));
        cmp("forwardBD", int'(forwardBD), int'(fwd_e(int'(rtD)) == 2));
        cmp("stallD", int'(stallD), int'(st));
        cmp("stallF", int'(stallF), int'(st && !excM));
        cmp("stallE", int'(stallE), 0);
        cmp("flushD", int'(flushD), int'(rd));
        cmp("flushE", int'(flushE), int'(st || rd));
        cmp("flushM", int'(flushM), int'(excM));
        cmp("flushW", int'(flushW), int'(excM));
        cmp("killE", int'(killE), kexp);
        cmp("busy", int'(busy), int'(m_busy[1]) * 2 + int'(m_busy[0]));
        cmp("stallcnt", int'(stallcnt), m_cnt);
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        rsD = 0; rtD = 0; srcAD = 0; srcBD = 0; dstD = 0; mcD = 0; branchD = 0;
        rsE = 0; rtE = 0; writeregE = 0; regwriteE = 0; memtoregE = 0;
        issueE = 0; tagE = 0; doneX = 0;
        writeregM = 0; regwriteM = 0; memtoregM = 0;
        writeregW = 0; regwriteW = 0; judgeM = 0; excM = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic pulse_reset();
        resetn = 1'b0;
        #2;
        resetn = 1'b1;
    endtask

    initial begin
        idle();
        resetn = 1'b0;
        repeat (2) cyc();
        cmp("reset_busy", int'(busy), 0);
        cmp("reset_cnt", int'(stallcnt), 0);
        cmp("reset_stallD", int'(stallD), 0);
        resetn = 1'b1;

        // Load-use: lw r8 in E, addu r8,r9 in D.
        cyc();
        memtoregE = 1; regwriteE = 1; writeregE = 8; rsD = 8; rtD = 9;
        #1;
        cmp("lw_stallD", int'(stallD), 1);
        cmp("lw_flushE", int'(flushE), 1);
        cmp("lw_stallF", int'(stallF), 1);
        cyc();
        regwriteM = 1; memtoregM = 1; writeregM = 8; rsE = 8; rtE = 9;
        #1;
        cmp("lw_fwdAE", int'(forwardAE), 2);
        cmp("lw_fwdBE", int'(forwardBE), 0);
        cmp("lw_next_stallD", int'(stallD), 0);

        // Forwarding: W path, M priority over W, r0 never forwarded, D path.
        cyc(); rtE = 9; writeregW = 9; regwriteW = 1; writeregM = 9;
        cyc(); rtE = 9; writeregW = 9; regwriteW = 1; writeregM = 9; regwriteM = 1;
        cyc(); rsE = 0; writeregM = 0; regwriteM = 1; writeregW = 0; regwriteW = 1;
        cyc(); rsD = 5; rtD = 6; writeregM = 5; regwriteM = 1;
        #1;
        cmp("fwdAD_lit", int'(forwardAD), 1);
        cmp("fwdBD_lit", int'(forwardBD), 0);

        // Branch operand stalls: from E, from a load in M, and r0 in E.
        cyc(); branchD = 1; rsD = 3; regwriteE = 1; writeregE = 3;
        cyc(); branchD = 1; rtD = 4; memtoregM = 1; writeregM = 4;
        cyc(); branchD = 1; rsD = 0; regwriteE = 1; writeregE = 0;
        cyc(); rsD = 3; regwriteE = 1; writeregE = 3;

        // Divide on ch0 writing HI; mfhi reaches D two cycles later.
        cyc(); pulse_reset();
        cyc(); issueE = 2'b01; tagE = 32;
        cyc();
        #1; cmp("div_busy", int'(busy), 1);
        for (int i = 2; i <= 20; i++) begin
            cyc();
            srcAD = 32;
            if (i == 20) doneX = 2'b01;
        end
        cyc(); srcAD = 32;
        #1;
        cmp("div_done_busy", int'(busy), 0);
        cmp("div_done_stall", int'(stallD), 0);
        cmp("div_stallcnt", int'(stallcnt), 19);

        // Non-blocking divide with independent followers, WAW and structural.
        cyc(); issueE = 2'b01; tagE = 33;
        cyc(); srcAD = 5; srcBD = 6; dstD = 7;
        cyc(); srcAD = 8; dstD = 9;
        cyc(); dstD = 33;
        cyc(); mcD = 2'b01;
        #1; cmp("struct_div", int'(stallD), 1);
        cyc(); mcD = 2'b10;
        #1; cmp("struct_mult", int'(stallD), 0);
        cyc(); issueE = 2'b10; tagE = 7;
        cyc(); srcBD = 7;
        cyc(); excM = 1; srcBD = 7;
        cyc(); doneX = 2'b10;
        cyc(); srcBD = 7; doneX = 2'b01;
        cyc(); doneX = 2'b11; srcAD = 33;
        cyc(); srcAD = 33;

        // Issue cancelled by exception and by mispredict.
        cyc(); issueE = 2'b01; tagE = 32; excM = 1;
        #1;
        cmp("exc_killE", int'(killE), 1);
        cmp("exc_flushW", int'(flushW), 1);
        cyc();
        #1; cmp("exc_busy", int'(busy), 0);
        cyc(); issueE = 2'b10; tagE = 33; judgeM = 1;
        cyc(); srcAD = 33;

        // Asynchronous reset while ch1 busy and stallcnt = 7.
        cyc(); pulse_reset();
        cyc(); issueE = 2'b10; tagE = 9;
        for (int i = 0; i < 7; i++) begin
            cyc(); srcAD = 9;
        end
        cyc();
        #1;
        cmp("pre_reset_busy", int'(busy), 2);
        cmp("pre_reset_cnt", int'(stallcnt), 7);
        #2;
        resetn = 1'b0;
        #1;
        cmp("async_busy", int'(busy), 0);
        cmp("async_cnt", int'(stallcnt), 0);
        cyc(); resetn = 1'b1;
        cyc();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
